// File: rtl/buffer_in_blk.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : buffer_in_blk                                                |
// | Description : Gathers BLK_ROWS image rows and streams them out column by   |
// |               column as one wide block word, with valid/ready handshakes   |
// |               and zero/replicate padding of a partial final block.         |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module buffer_in_blk #(
    parameter int BAND_WIDTH    = 512,
    parameter int BLK_ROWS      = 4,
    parameter int IM_WIDTH      = 800,
    parameter int IM_HEIGHT     = 800,
    parameter int IM_DATA_WIDTH = 8,
    parameter int IM_CHN_CNT    = 4,
    parameter int PAD_MODE      = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_done,
    input  logic [BAND_WIDTH-1:0]          i_im_data,
    input  logic                           i_im_vld,
    output logic                           o_im_rdy,
    output logic [BLK_ROWS*BAND_WIDTH-1:0] o_im_data,
    output logic                           o_im_vld,
    input  logic                           i_im_rdy,
    output logic [BLK_ROWS-1:0]            o_rows_mask,
    output logic                           o_blk_last,
    output logic                           o_frame_last
);

    localparam int COL_CNT = IM_WIDTH * IM_DATA_WIDTH * IM_CHN_CNT / BAND_WIDTH;
    localparam int c_CW    = (COL_CNT > 1)   ? $clog2(COL_CNT)   : 1;
    localparam int c_SW    = (BLK_ROWS > 1)  ? $clog2(BLK_ROWS)  : 1;
    localparam int c_RW    = (IM_HEIGHT > 1) ? $clog2(IM_HEIGHT) : 1;
    localparam int c_NBUF  = (BLK_ROWS > 1)  ? BLK_ROWS - 1      : 1;

    localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(COL_CNT - 1);
    localparam logic [c_SW-1:0] c_SLOT_TOP = c_SW'(BLK_ROWS - 1);
    localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(IM_HEIGHT - 1);

    generate
        if ((IM_WIDTH * IM_DATA_WIDTH * IM_CHN_CNT) % BAND_WIDTH != 0) begin : g_bad_geom
            $fatal(1, "buffer_in_blk: row size is not a whole number of BAND_WIDTH beats");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_PASS  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // A single-row block has nothing to buffer, so it lives in PASS permanently.
    localparam state_t c_ST_START = (BLK_ROWS == 1) ? ST_PASS : ST_FILL;

    state_t          r_state, w_state_nxt;
    logic [c_CW-1:0] r_c, w_c_nxt;
    logic [c_SW-1:0] r_s, w_s_nxt;
    logic [c_RW-1:0] r_r, w_r_nxt;
    logic            w_lb_we;
    logic            w_col_wrap;
    logic            w_row_last;
    logic [BAND_WIDTH-1:0] w_rd [c_NBUF];
    logic [BAND_WIDTH-1:0] w_pad;

    assign w_col_wrap = (r_c == c_COL_LAST);
    assign w_row_last = (r_r == c_ROW_LAST);

    generate
        if (BLK_ROWS > 1) begin : g_linebuf
            for (genvar j = 0; j < BLK_ROWS - 1; j++) begin : g_row
                logic [BAND_WIDTH-1:0] r_mem [COL_CNT];
                always_ff @(posedge clk) begin
                    if (w_lb_we && (r_s == c_SW'(j))) begin
                        r_mem[r_c] <= i_im_data;
                    end
                end
                assign w_rd[j] = r_mem[r_c];
            end
        end else begin : g_no_linebuf
            assign w_rd[0] = '0;
        end
    endgenerate

    // Replicate source is the newest valid row, slot s-1.
    always_comb begin
        w_pad = '0;
        if (PAD_MODE != 0) begin
            for (int j = 0; j < c_NBUF; j++) begin
                if (int'(r_s) == j + 1) begin
                    w_pad = w_rd[j];
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < BLK_ROWS; k++) begin : g_lane
            logic [BAND_WIDTH-1:0] w_lane;
            if (k < BLK_ROWS - 1) begin : g_buf_lane
                always_comb begin
                    w_lane = '0;
                    if (r_state == ST_PASS || (r_state == ST_FLUSH && int'(r_s) > k)) begin
                        w_lane = w_rd[k];
                    end else if (r_state == ST_FLUSH) begin
                        w_lane = w_pad;
                    end
                end
            end else begin : g_top_lane
                always_comb begin
                    w_lane = '0;
                    if (r_state == ST_PASS) begin
                        w_lane = i_im_data;
                    end else if (r_state == ST_FLUSH) begin
                        w_lane = w_pad;
                    end
                end
            end
            assign o_im_data[k*BAND_WIDTH +: BAND_WIDTH] = w_lane;
            assign o_rows_mask[k] = (r_state == ST_PASS) ||
                                    (r_state == ST_FLUSH && int'(r_s) > k);
        end
    endgenerate

    always_comb begin
        w_state_nxt  = r_state;
        w_c_nxt      = r_c;
        w_s_nxt      = r_s;
        w_r_nxt      = r_r;
        w_lb_we      = 1'b0;
        o_im_rdy     = 1'b0;
        o_im_vld     = 1'b0;
        o_blk_last   = 1'b0;
        o_frame_last = 1'b0;
        // During rst or i_done both sides stay quiet; the register block clears state.
        if (!rst && !i_done) begin
            case (r_state)
                ST_FILL: begin
                    o_im_rdy = 1'b1;
                    if (i_im_vld) begin
                        w_lb_we = 1'b1;
                        w_c_nxt = w_col_wrap ? '0 : r_c + 1'b1;
                        if (w_col_wrap) begin
                            w_s_nxt = r_s + 1'b1;
                            w_r_nxt = r_r + 1'b1;
                            if (w_row_last) begin
                                w_state_nxt = ST_FLUSH;
                                w_r_nxt     = '0;
                            end else if (w_s_nxt == c_SLOT_TOP) begin
                                w_state_nxt = ST_PASS;
                            end
                        end
                    end
                end
                ST_PASS: begin
                    o_im_rdy     = i_im_rdy;
                    o_im_vld     = i_im_vld;
                    o_blk_last   = i_im_vld && w_col_wrap;
                    o_frame_last = i_im_vld && w_col_wrap && w_row_last;
                    if (i_im_vld && i_im_rdy) begin
                        w_c_nxt = w_col_wrap ? '0 : r_c + 1'b1;
                        if (w_col_wrap) begin
                            w_s_nxt     = '0;
                            w_r_nxt     = w_row_last ? '0 : r_r + 1'b1;
                            w_state_nxt = c_ST_START;
                        end
                    end
                end
                ST_FLUSH: begin
                    o_im_vld     = 1'b1;
                    o_blk_last   = w_col_wrap;
                    o_frame_last = w_col_wrap;
                    if (i_im_rdy) begin
                        w_c_nxt = w_col_wrap ? '0 : r_c + 1'b1;
                        if (w_col_wrap) begin
                            w_s_nxt     = '0;
                            w_r_nxt     = '0;
                            w_state_nxt = c_ST_START;
                        end
                    end
                end
                default: begin
                    w_state_nxt = c_ST_START;
                    w_c_nxt     = '0;
                    w_s_nxt     = '0;
                    w_r_nxt     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_done) begin
            r_state <= c_ST_START;
            r_c     <= '0;
            r_s     <= '0;
            r_r     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_c     <= w_c_nxt;
            r_s     <= w_s_nxt;
            r_r     <= w_r_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_buffer_in_blk.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_buffer_in_blk                                             |
// | Description : Self-checking bench for buffer_in_blk across four geometries |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_buffer_in_blk;

    localparam int c_BW    = 32;
    localparam int c_COLS  = 8;
    localparam int c_LIMIT = 4000;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   mask;
        logic         bl;
        logic         fl;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_all, rst_one, done_one, vin, rdn;
    logic [31:0] din;
    int          sel;
    int          checks, passed, fails;
    beat_t       exp_q[$];

    logic         rdy_a, vld_a, bl_a, fl_a, rdy_b, vld_b, bl_b, fl_b;
    logic         rdy_c, vld_c, bl_c, fl_c, rdy_d, vld_d, bl_d, fl_d;
    logic [127:0] dat_a, dat_b, dat_c;
    logic [31:0]  dat_d;
    logic [3:0]   msk_a, msk_b, msk_c;
    logic         msk_d;

    logic         obs_rdy, obs_vld, obs_bl, obs_fl;
    logic [127:0] obs_data;
    logic [3:0]   obs_mask;

    // Instance 0: 8 rows, 4-row blocks; 1/2: 10 rows with zero / replicate pad; 3: single-row blocks.
    buffer_in_blk #(.BAND_WIDTH(32), .BLK_ROWS(4), .IM_WIDTH(8), .IM_HEIGHT(8),
                    .IM_DATA_WIDTH(8), .IM_CHN_CNT(4), .PAD_MODE(0)) u_dut_a (
        .clk(clk), .rst(rst_all || (sel == 0 && rst_one)), .i_done(sel == 0 && done_one),
        .i_im_data(din), .i_im_vld(vin && sel == 0), .o_im_rdy(rdy_a), .o_im_data(dat_a),
        .o_im_vld(vld_a), .i_im_rdy(rdn && sel == 0), .o_rows_mask(msk_a),
        .o_blk_last(bl_a), .o_frame_last(fl_a));

    buffer_in_blk #(.BAND_WIDTH(32), .BLK_ROWS(4), .IM_WIDTH(8), .IM_HEIGHT(10),
                    .IM_DATA_WIDTH(8), .IM_CHN_CNT(4), .PAD_MODE(0)) u_dut_b (
        .clk(clk), .rst(rst_all || (sel == 1 && rst_one)), .i_done(sel == 1 && done_one),
        .i_im_data(din), .i_im_vld(vin && sel == 1), .o_im_rdy(rdy_b), .o_im_data(dat_b),
        .o_im_vld(vld_b), .i_im_rdy(rdn && sel == 1), .o_rows_mask(msk_b),
        .o_blk_last(bl_b), .o_frame_last(fl_b));

    buffer_in_blk #(.BAND_WIDTH(32), .BLK_ROWS(4), .IM_WIDTH(8), .IM_HEIGHT(10),
                    .IM_DATA_WIDTH(8), .IM_CHN_CNT(4), .PAD_MODE(1)) u_dut_c (
        .clk(clk), .rst(rst_all || (sel == 2 && rst_one)), .i_done(sel == 2 && done_one),
        .i_im_data(din), .i_im_vld(vin && sel == 2), .o_im_rdy(rdy_c), .o_im_data(dat_c),
        .o_im_vld(vld_c), .i_im_rdy(rdn && sel == 2), .o_rows_mask(msk_c),
        .o_blk_last(bl_c), .o_frame_last(fl_c));

    buffer_in_blk #(.BAND_WIDTH(32), .BLK_ROWS(1), .IM_WIDTH(8), .IM_HEIGHT(8),
                    .IM_DATA_WIDTH(8), .IM_CHN_CNT(4), .PAD_MODE(0)) u_dut_d (
        .clk(clk), .rst(rst_all || (sel == 3 && rst_one)), .i_done(sel == 3 && done_one),
        .i_im_data(din), .i_im_vld(vin && sel == 3), .o_im_rdy(rdy_d), .o_im_data(dat_d),
        .o_im_vld(vld_d), .i_im_rdy(rdn && sel == 3), .o_rows_mask(msk_d),
        .o_blk_last(bl_d), .o_frame_last(fl_d));

    always_comb begin
        obs_rdy = 1'b0; obs_vld = 1'b0; obs_bl = 1'b0; obs_fl = 1'b0;
        obs_data = '0;  obs_mask = '0;
        case (sel)
            0: begin obs_rdy = rdy_a; obs_vld = vld_a; obs_data = dat_a; obs_mask = msk_a; obs_bl = bl_a; obs_fl = fl_a; end
            1: begin obs_rdy = rdy_b; obs_vld = vld_b; obs_data = dat_b; obs_mask = msk_b; obs_bl = bl_b; obs_fl = fl_b; end
            2: begin obs_rdy = rdy_c; obs_vld = vld_c; obs_data = dat_c; obs_mask = msk_c; obs_bl = bl_c; obs_fl = fl_c; end
            3: begin obs_rdy = rdy_d; obs_vld = vld_d; obs_data = {96'd0, dat_d}; obs_mask = {3'd0, msk_d}; obs_bl = bl_d; obs_fl = fl_d; end
            default: ;
        endcase
    end

    function automatic int cfg_h(input int n);
        return (n == 1 || n == 2) ? 10 : 8;
    endfunction

    function automatic int cfg_br(input int n);
        return (n == 3) ? 1 : 4;
    endfunction

    function automatic int cfg_pad(input int n);
        return (n == 2) ? 1 : 0;
    endfunction

    function automatic logic [31:0] beat_val(input int idx);
        return {16'(idx / c_COLS), 16'(idx % c_COLS)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected output stream derived from frame geometry: block b covers rows b*BR.., padded lanes
    // are zero or a copy of the last real row.
    task automatic build_expected(input int n);
        int    h, br, nv, row;
        beat_t e;
        h  = cfg_h(n);
        br = cfg_br(n);
        exp_q.delete();
        for (int b = 0; b * br < h; b++) begin
            nv = (h - b * br < br) ? (h - b * br) : br;
            for (int j = 0; j < c_COLS; j++) begin
                e.data = '0;
                for (int k = 0; k < br; k++) begin
                    row = b * br + ((k < nv) ? k : nv - 1);
                    if (k < nv || cfg_pad(n) != 0) e.data[k*c_BW +: c_BW] = {16'(row), 16'(j)};
                end
                e.mask = 4'((1 << nv) - 1);
                e.bl   = (j == c_COLS - 1);
                e.fl   = (j == c_COLS - 1) && (b * br + nv == h);
                exp_q.push_back(e);
            end
        end
    endtask

    // Streams one frame into instance n; ab_kind 1 = i_done, 2 = rst once ab_at beats have left.
    task automatic run_frame(input int n, input int pct, input int ab_kind, input int ab_at);
        int           br, total_in, total_out, in_idx, out_idx, cyc;
        logic         hold, stalled, in_hs, out_hs, aborted;
        logic [127:0] held;
        br = cfg_br(n);
        build_expected(n);
        total_in  = cfg_h(n) * c_COLS;
        total_out = exp_q.size();
        in_idx = 0; out_idx = 0; cyc = 0;
        hold = 1'b0; stalled = 1'b0; aborted = 1'b0; held = '0;
        sel = n;
        while (!aborted && out_idx < total_out && cyc < c_LIMIT) begin
            if (!hold) begin
                vin = (in_idx < total_in) && (int'($urandom_range(99)) >= pct);
                din = beat_val(in_idx);
            end
            rdn = (int'($urandom_range(99)) >= pct);
            if (ab_kind != 0 && out_idx == ab_at) begin
                vin = 1'b1; din = beat_val(in_idx); rdn = 1'b1;
                if (ab_kind == 1) done_one = 1'b1;
                else              rst_one  = 1'b1;
                @(negedge clk);
                chk("abort_cycle_vld", obs_vld, 0);
                if (ab_kind == 2) chk("abort_cycle_rdy", obs_rdy, 0);
                @(posedge clk); #1;
                done_one = 1'b0; rst_one = 1'b0; vin = 1'b0;
                @(negedge clk);
                chk("after_abort_vld", obs_vld, 0);
                chk("after_abort_rdy", obs_rdy, 1);
                @(posedge clk); #1;
                aborted = 1'b1;
            end else begin
                @(negedge clk);
                in_hs  = vin && obs_rdy;
                out_hs = obs_vld && rdn;
                if (stalled) begin
                    chk("stall_hold_vld", obs_vld, 1);
                    chk("stall_hold_data", obs_data, held);
                end
                if (in_idx < total_in && ((in_idx / c_COLS) % br) != br - 1) begin
                    chk("fill_vld", obs_vld, 0);
                    chk("fill_rdy", obs_rdy, 1);
                end
                if (in_idx == total_in && out_idx < total_out) chk("flush_rdy", obs_rdy, 0);
                if (out_hs && out_idx < total_out) begin
                    chk("data", obs_data, exp_q[out_idx].data);
                    chk("mask", obs_mask, exp_q[out_idx].mask);
                    chk("blk_last", obs_bl, exp_q[out_idx].bl);
                    chk("frame_last", obs_fl, exp_q[out_idx].fl);
                end
                stalled = obs_vld && !rdn;
                held    = obs_data;
                hold    = vin && !in_hs;
                if (in_hs)  in_idx++;
                if (out_hs) out_idx++;
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (ab_kind == 0) chk("beats_out", out_idx, total_out);
        vin = 1'b0;
        rdn = 1'b0;
    endtask

    initial begin
        checks = 0; passed = 0; fails = 0;
        sel = 0; rst_all = 1'b1; rst_one = 1'b0; done_one = 1'b0;
        vin = 1'b0; rdn = 1'b0; din = '0;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_vld_a", obs_vld, 0);
        chk("rst_rdy_a", obs_rdy, 0);
        sel = 1; #1;
        chk("rst_rdy_b", obs_rdy, 0);
        @(posedge clk); #1;
        rst_all = 1'b0;
        sel = 0;
        @(negedge clk);
        chk("post_rst_vld_a", obs_vld, 0);
        chk("post_rst_rdy_a", obs_rdy, 1);
        @(posedge clk); #1;

        run_frame(0, 0, 0, 0);
        run_frame(0, 30, 0, 0);
        run_frame(0, 30, 0, 0);
        run_frame(1, 0, 0, 0);
        run_frame(1, 30, 0, 0);
        run_frame(2, 30, 0, 0);
        run_frame(0, 0, 1, 3);
        run_frame(0, 0, 0, 0);
        run_frame(1, 0, 2, 19);
        run_frame(1, 0, 0, 0);
        run_frame(3, 30, 0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
